// File: rtl/spi_master_xfer.sv
// ---------------------------------------------------------------------------
// spi_master_xfer
//
// SPI mode-0 initiator. A start pulse, taken while idle, loads one DATA_W-bit
// word which is shifted out MSB first on mosi while the reply on miso is
// shifted in, full duplex. All outputs come straight from flops.
//
// Frame timeline, counted in clk edges after the edge that accepts start:
//   cs falls together with busy, then 1 + CS_SETUP cycles pass with sclk low,
//   then DATA_W bit periods of CLK_DIV cycles low followed by CLK_DIV cycles
//   high, then CS_HOLD cycles with sclk low. The next edge raises cs, drops
//   busy and pulses done with rx_data updated.
//   The done pulse therefore lands 1+CS_SETUP+2*CLK_DIV*DATA_W+CS_HOLD edges
//   after acceptance.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          transfer request, sampled only while idle
//   tx_data        word to send, captured on the accepted start cycle
//   busy           high while a frame is in progress
//   done           one-cycle pulse, rx_data valid
//   rx_data        last received word, held until the next done
//   sclk/cs/mosi   SPI pad outputs (cs active low)
//   *_en           pad output enables, tied high
//   miso           SPI serial input, asynchronous to clk
// ---------------------------------------------------------------------------
module spi_master_xfer #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              sclk_en,
  output logic              cs,
  output logic              cs_en,
  output logic              mosi,
  output logic              mosi_en,
  input  logic              miso
);

  localparam int BIT_W   = $clog2(DATA_W) + 1;
  localparam int DIV_W   = $clog2(CLK_DIV) + 1;
  localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int GAP_W   = $clog2(GAP_MAX + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_e;

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] tx_sr_q,   tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              sclk_q,    sclk_d;
  logic              cs_q,      cs_d;
  logic              mosi_q,    mosi_d;

  // Two-flop synchronizer; miso_s_q is the only version of miso the FSM sees.
  logic miso_meta_q;
  logic miso_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_meta_q <= 1'b0;
      miso_s_q    <= 1'b0;
    end else begin
      miso_meta_q <= miso;
      miso_s_q    <= miso_meta_q;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register sees the
  // pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  // NOTE: every value is given its hold default before the case statement, so
  // no path through the block leaves a signal unassigned and no latch forms.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (start) begin
          // mosi presents the MSB at once; tx_sr keeps the remaining bits
          // left-aligned so the next bit out is always its MSB.
          mosi_d    = tx_data[DATA_W-1];
          tx_sr_d   = {tx_data[DATA_W-2:0], 1'b0};
          busy_d    = 1'b1;
          cs_d      = 1'b0;
          gap_cnt_d = '0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        // One cycle for cs to settle plus CS_SETUP full clocks before the
        // first bit period opens.
        if (gap_cnt_q == GAP_W'(CS_SETUP)) begin
          div_cnt_d = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
          state_d   = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      SHIFT: begin
        // Sample late in the high phase so the synchronized miso reflects a
        // value the target set up before sclk rose.
        if (sclk_q && (div_cnt_q == DIV_W'(2))) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_s_q};
        end

        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              // Last bit: mosi keeps its value through HOLD.
              gap_cnt_d = '0;
              state_d   = HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              mosi_d    = tx_sr_q[DATA_W-1];
              tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (gap_cnt_q == GAP_W'(CS_HOLD - 1)) begin
          cs_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;

  assign sclk_en = 1'b1;
  assign cs_en   = 1'b1;
  assign mosi_en = 1'b1;

endmodule

// File: tb/tb_spi_master_xfer.sv
// ---------------------------------------------------------------------------
// tb_spi_master_xfer
//
// Self-checking bench for spi_master_xfer. A frame model tracks the number of
// clk edges since the accepting edge and derives busy/done/cs/sclk/mosi and
// rx_data from the frame timeline arithmetic; one compare process checks the
// DUT against it on every falling clk edge. Directed scenarios add literal
// expectations (latency, received words, pulse counts). miso comes either
// from a mosi loopback or from a small mode-0 target that presents its MSB on
// cs fall and the following bits on each sclk fall.
// ---------------------------------------------------------------------------
module tb_spi_master_xfer;

  localparam int DATA_W    = 8;
  localparam int CLK_DIV   = 4;
  localparam int CS_SETUP  = 2;
  localparam int CS_HOLD   = 2;
  localparam int SHIFT0    = 1 + CS_SETUP;
  localparam int SHIFT_LEN = 2 * CLK_DIV * DATA_W;
  localparam int FRAME     = SHIFT0 + SHIFT_LEN + CS_HOLD;

  logic              clk;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              sclk_en;
  logic              cs;
  logic              cs_en;
  logic              mosi;
  logic              mosi_en;
  logic              miso;

  spi_master_xfer #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .tx_data(tx_data),
    .busy   (busy),
    .done   (done),
    .rx_data(rx_data),
    .sclk   (sclk),
    .sclk_en(sclk_en),
    .cs     (cs),
    .cs_en  (cs_en),
    .mosi   (mosi),
    .mosi_en(mosi_en),
    .miso   (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // miso sources
  // -------------------------------------------------------------------------
  logic              loop_mode;
  logic [DATA_W-1:0] tgt_word;
  int                tgt_idx       = 0;
  logic              tgt_cs_last   = 1'b1;
  logic              tgt_sclk_last = 1'b0;
  logic              tgt_miso;

  always @(cs or sclk) begin
    if (!cs && tgt_cs_last) begin
      tgt_idx = DATA_W - 1;
    end else if (!cs && !sclk && tgt_sclk_last && tgt_idx > 0) begin
      tgt_idx = tgt_idx - 1;
    end
    tgt_cs_last   = cs;
    tgt_sclk_last = sclk;
  end

  assign tgt_miso = tgt_word[tgt_idx];
  assign miso     = loop_mode ? mosi : tgt_miso;

  // -------------------------------------------------------------------------
  // Frame model: m_n = edges since the accepting edge, -1 when idle.
  // -------------------------------------------------------------------------
  int                m_n = -1;
  logic [DATA_W-1:0] m_tx;
  logic [DATA_W-1:0] m_rx_next;
  logic [DATA_W-1:0] m_rx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n  <= -1;
      m_rx <= '0;
    end else if ((m_n < 0 || m_n == FRAME) && start) begin
      m_n       <= 0;
      m_tx      <= tx_data;
      m_rx_next <= loop_mode ? tx_data : tgt_word;
    end else if (m_n >= 0) begin
      m_n <= (m_n >= FRAME) ? -1 : m_n + 1;
      if (m_n == FRAME - 1) m_rx <= m_rx_next;
    end
  end

  function automatic logic exp_sclk(input int n);
    int s;
    s = n - SHIFT0;
    if (n < 0 || s < 0 || s >= SHIFT_LEN) return 1'b0;
    return ((s % (2 * CLK_DIV)) >= CLK_DIV);
  endfunction

  function automatic logic exp_mosi(input int n, input logic [DATA_W-1:0] tx);
    int s;
    int b;
    s = n - SHIFT0;
    b = (s < 0) ? 0 : s / (2 * CLK_DIV);
    if (b > DATA_W - 1) b = DATA_W - 1;
    return tx[DATA_W-1-b];
  endfunction

  // -------------------------------------------------------------------------
  // Compare process and event counters, all on the falling edge.
  // -------------------------------------------------------------------------
  logic cmp_en = 1'b0;

  initial begin
    logic in_frame;
    forever begin
      @(negedge clk);
      if (!reset && cmp_en) begin
        in_frame = (m_n >= 0) && (m_n < FRAME);
        check("busy", busy, in_frame);
        check("done", done, (m_n == FRAME));
        check("cs", cs, !in_frame);
        check("sclk", sclk, exp_sclk(m_n));
        if (in_frame) check("mosi", mosi, exp_mosi(m_n, m_tx));
        check("rx_data", rx_data, m_rx);
      end
    end
  end

  int   rise_total     = 0;
  int   mosi_low_total = 0;
  int   done_total     = 0;
  logic sclk_last      = 1'b0;

  always @(negedge clk) begin
    sclk_last <= sclk;
    if (!reset) begin
      if (sclk && !sclk_last) rise_total <= rise_total + 1;
      if (!cs && !mosi)       mosi_low_total <= mosi_low_total + 1;
      if (done)               done_total <= done_total + 1;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after a rising edge.
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulses start for one edge; returns the cycle number seen on the falling
  // edge right after the accepting edge.
  task automatic do_start(input logic [DATA_W-1:0] w, output int acc_cyc);
    start   = 1'b1;
    tx_data = w;
    tick();
    start   = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output int at_cyc);
    logic seen;
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    check("done_timeout", seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  initial begin
    int                a;
    int                d;
    int                d2;
    int                r0;
    int                m0;
    int                n0;
    int                spur;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] w2;

    reset     = 1'b1;
    start     = 1'b0;
    tx_data   = '0;
    loop_mode = 1'b1;
    tgt_word  = '0;

    // Reset values.
    repeat (3) tick();
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs", cs, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_data, '0);
    check("rst_mosi", mosi, 1'b0);
    check("pad_en", {sclk_en, cs_en, mosi_en}, 3'b111);
    reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();

    // Loopback of A5.
    r0 = rise_total;
    do_start(8'hA5, a);
    check("a5_cs_low", cs, 1'b0);
    wait_done(FRAME + 20, d);
    check("a5_latency", d - a, 69);
    check("a5_rx", rx_data, 8'hA5);
    check("a5_cs_at_done", cs, 1'b1);
    check("a5_sclk_pulses", rise_total - r0, 8);
    tick();

    // Target returns 3C while mosi sends FF.
    loop_mode = 1'b0;
    tgt_word  = 8'h3C;
    m0 = mosi_low_total;
    do_start(8'hFF, a);
    wait_done(FRAME + 20, d);
    check("tgt_rx", rx_data, 8'h3C);
    check("tgt_mosi_low_cycles", mosi_low_total - m0, 0);
    tick();

    // Second start while busy, with different tx_data, is ignored.
    loop_mode = 1'b1;
    n0 = done_total;
    do_start(8'h5A, a);
    repeat (9) tick();
    start   = 1'b1;
    tx_data = 8'h00;
    tick();
    start   = 1'b0;
    wait_done(FRAME + 20, d);
    check("ign_rx", rx_data, 8'h5A);
    repeat (80) tick();
    check("ign_done_count", done_total - n0, 1);

    // Back-to-back: start held high through the done cycle.
    w  = DATA_W'($urandom);
    w2 = DATA_W'($urandom);
    start   = 1'b1;
    tx_data = w;
    tick();
    wait_done(FRAME + 20, d);
    check("b2b_rx1", rx_data, w);
    check("b2b_cs_high_at_done", cs, 1'b1);
    tx_data = w2;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("b2b_cs_low_after_gap", cs, 1'b0);
    wait_done(FRAME + 20, d2);
    check("b2b_done_spacing", d2 - d, 70);
    check("b2b_rx2", rx_data, w2);
    tick();

    // Asynchronous reset in the middle of the fourth bit.
    n0 = done_total;
    do_start(8'h96, a);
    repeat (SHIFT0 + 3 * 2 * CLK_DIV + 3) @(negedge clk);
    check("pre_reset_cs", cs, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_cs", cs, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_rx", rx_data, '0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (80) tick();
    check("midrst_no_done", done_total - n0, 0);
    do_start(8'hC3, a);
    wait_done(FRAME + 20, d);
    check("after_rst_rx", rx_data, 8'hC3);
    check("after_rst_latency", d - a, 69);
    tick();

    // Randomized frames: loopback or target, spurious starts mid-frame.
    for (int k = 0; k < 8; k++) begin
      loop_mode = 1'($urandom_range(0, 1));
      tgt_word  = DATA_W'($urandom);
      w         = DATA_W'($urandom);
      do_start(w, a);
      spur = $urandom_range(2, 55);
      repeat (spur) tick();
      start   = 1'b1;
      tx_data = DATA_W'($urandom);
      tick();
      start = 1'b0;
      wait_done(FRAME + 20, d);
      check("rand_rx", rx_data, loop_mode ? w : tgt_word);
      check("rand_latency", d - a, 69);
      repeat ($urandom_range(1, 5)) tick();
    end

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
